iob_fifo_wr_ptr_ctrl: RTL and testbench

//  Write-side pointer/flag controller of the dual-clock FIFO, in the write clock domain.

---
 rtl/iob_fifo_wr_ptr_ctrl_pkg.sv | 28 ++
 rtl/iob_fifo_wr_ptr_ctrl_if.sv | 24 ++
 rtl/iob_fifo_wr_ptr_ctrl_sync.sv | 29 ++
 rtl/iob_fifo_wr_ptr_ctrl.sv | 74 +++++++
 tb/tb_iob_fifo_wr_ptr_ctrl.sv | 183 ++++++++++++++++++
 5 files changed

// File: rtl/iob_fifo_wr_ptr_ctrl_pkg.sv
// rtl/iob_fifo_wr_ptr_ctrl_pkg.sv - shared pointer helpers for the dual-clock FIFO controllers
package iob_fifo_wr_ptr_ctrl_pkg;

    localparam int MAX_PTR_W = 32;

    function automatic int ptr_w(input int addr_w);
        return addr_w + 1;
    endfunction

    function automatic int fifo_depth(input int addr_w);
        return 1 << addr_w;
    endfunction

    function automatic logic [MAX_PTR_W-1:0] bin2gray(input logic [MAX_PTR_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    // Zero-extended inputs keep the upper XOR terms at zero, so one width serves every P.
    function automatic logic [MAX_PTR_W-1:0] gray2bin(input logic [MAX_PTR_W-1:0] g);
        logic [MAX_PTR_W-1:0] b;
        b[MAX_PTR_W-1] = g[MAX_PTR_W-1];
        for (int i = MAX_PTR_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/iob_fifo_wr_ptr_ctrl_if.sv
// rtl/iob_fifo_wr_ptr_ctrl_if.sv - write-port and pointer-exchange signals of the FIFO write controller
interface iob_fifo_wr_ptr_ctrl_if #(
    parameter int ADDR_W = 4
);
    logic              wr_en_i;
    logic [ADDR_W:0]   rd_gptr_i;
    logic [ADDR_W:0]   wr_gptr_o;
    logic [ADDR_W-1:0] wr_addr_o;
    logic              wr_we_o;
    logic              full_o;
    logic              afull_o;
    logic [ADDR_W:0]   level_o;
    logic              overflow_o;

    modport slave (
        input  wr_en_i, rd_gptr_i,
        output wr_gptr_o, wr_addr_o, wr_we_o, full_o, afull_o, level_o, overflow_o
    );

    modport master (
        output wr_en_i, rd_gptr_i,
        input  wr_gptr_o, wr_addr_o, wr_we_o, full_o, afull_o, level_o, overflow_o
    );
endinterface

// File: rtl/iob_fifo_wr_ptr_ctrl_sync.sv
// rtl/iob_fifo_wr_ptr_ctrl_sync.sv - multi-flop synchroniser for the read-domain Gray pointer
module iob_fifo_wr_ptr_ctrl_sync #(
    parameter int W      = 5,
    parameter int STAGES = 2
) (
    input  logic         clk_i,
    input  logic         cke_i,
    input  logic         arst_i,
    input  logic         rst_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);
    logic [W-1:0] stage [STAGES];

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < STAGES; i++) stage[i] <= '0;
        end else if (cke_i) begin
            if (rst_i) begin
                for (int i = 0; i < STAGES; i++) stage[i] <= '0;
            end else begin
                stage[0] <= d_i;
                for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
            end
        end
    end

    assign q_o = stage[STAGES-1];
endmodule

// File: rtl/iob_fifo_wr_ptr_ctrl.sv
// rtl/iob_fifo_wr_ptr_ctrl.sv - write-side pointer and flag controller of the dual-clock FIFO
module iob_fifo_wr_ptr_ctrl
    import iob_fifo_wr_ptr_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 4,
    parameter int SYNC_STAGES = 2,
    parameter int AFULL_LVL   = 2**ADDR_W - 1
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    arst_i,
    input  logic                    rst_i,
    iob_fifo_wr_ptr_ctrl_if.slave   bus
);
    localparam int P = ptr_w(ADDR_W);
    localparam int D = fifo_depth(ADDR_W);

    logic [P-1:0] wr_bin, wr_bin_nxt, wr_gptr_nxt;
    logic [P-1:0] rd_gsync, rd_bin_sync, lvl_nxt;
    logic [P-1:0] level_r, wr_gptr_r;
    logic         full_r, afull_r, overflow_r;
    logic         accept;

    iob_fifo_wr_ptr_ctrl_sync #(.W(P), .STAGES(SYNC_STAGES)) u_rd_sync (
        .clk_i  (clk_i),
        .cke_i  (cke_i),
        .arst_i (arst_i),
        .rst_i  (rst_i),
        .d_i    (bus.rd_gptr_i),
        .q_o    (rd_gsync)
    );

    // full_r is next-state registered, so a refused write never needs a combinational level path.
    assign accept      = cke_i & bus.wr_en_i & ~full_r;
    assign wr_bin_nxt  = wr_bin + P'(accept);
    assign wr_gptr_nxt = P'(bin2gray(MAX_PTR_W'(wr_bin_nxt)));
    assign rd_bin_sync = P'(gray2bin(MAX_PTR_W'(rd_gsync)));
    assign lvl_nxt     = wr_bin_nxt - rd_bin_sync;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            wr_bin     <= '0;
            wr_gptr_r  <= '0;
            level_r    <= '0;
            full_r     <= 1'b0;
            afull_r    <= 1'b0;
            overflow_r <= 1'b0;
        end else if (cke_i) begin
            if (rst_i) begin
                wr_bin     <= '0;
                wr_gptr_r  <= '0;
                level_r    <= '0;
                full_r     <= 1'b0;
                afull_r    <= 1'b0;
                overflow_r <= 1'b0;
            end else begin
                wr_bin     <= wr_bin_nxt;
                wr_gptr_r  <= wr_gptr_nxt;
                level_r    <= lvl_nxt;
                full_r     <= (lvl_nxt == P'(D));
                afull_r    <= (lvl_nxt >= P'(AFULL_LVL));
                overflow_r <= bus.wr_en_i & full_r;
            end
        end
    end

    assign bus.wr_gptr_o  = wr_gptr_r;
    assign bus.wr_addr_o  = wr_bin[ADDR_W-1:0];
    assign bus.wr_we_o    = accept;
    assign bus.full_o     = full_r;
    assign bus.afull_o    = afull_r;
    assign bus.level_o    = level_r;
    assign bus.overflow_o = overflow_r & cke_i;
endmodule

// File: tb/tb_iob_fifo_wr_ptr_ctrl.sv
// tb/tb_iob_fifo_wr_ptr_ctrl.sv - directed vector bench for the FIFO write pointer controller
module tb_iob_fifo_wr_ptr_ctrl;
    logic clk = 1'b0;
    logic cke, arst, rst;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    iob_fifo_wr_ptr_ctrl_if #(.ADDR_W(4)) bus ();

    iob_fifo_wr_ptr_ctrl #(.ADDR_W(4), .SYNC_STAGES(2), .AFULL_LVL(15)) dut (
        .clk_i  (clk),
        .cke_i  (cke),
        .arst_i (arst),
        .rst_i  (rst),
        .bus    (bus)
    );

    typedef struct {
        logic       wr_en;
        logic [4:0] rd_g;
        logic       exp_we;
        logic [4:0] exp_gptr;
        logic [4:0] exp_level;
        logic       exp_full;
        logic       exp_afull;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs[$];

    function automatic logic [4:0] g(input int b);
        int m;
        m = b & 31;
        return 5'(m ^ (m >> 1));
    endfunction

    function automatic int g2b(input logic [4:0] gv);
        int r;
        r = 0;
        for (int i = 4; i >= 0; i--) r |= ((((r >> (i + 1)) & 1) ^ int'(gv[i])) << i);
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gptr"}, int'(bus.wr_gptr_o), 0);
        chk({tag, "_level"}, int'(bus.level_o), 0);
        chk({tag, "_full"}, int'(bus.full_o), 0);
        chk({tag, "_afull"}, int'(bus.afull_o), 0);
        chk({tag, "_addr"}, int'(bus.wr_addr_o), 0);
        chk({tag, "_ovf"}, int'(bus.overflow_o), 0);
    endtask

    task automatic add_vec(input logic w, input logic [4:0] rg, input logic we, input int gp,
                           input int lv, input logic f, input logic af, input logic ov);
        vec_t v;
        v.wr_en = w; v.rd_g = rg; v.exp_we = we; v.exp_gptr = 5'(gp);
        v.exp_level = 5'(lv); v.exp_full = f; v.exp_afull = af; v.exp_ovf = ov;
        vecs.push_back(v);
    endtask

    task automatic write_n(input int n);
        bus.wr_en_i = 1'b1;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int wb, rb, s1, s2, lvl_m, writes, cyc;
    logic full_m, ovf_m, wen, wrapped;
    logic [4:0] prev_gptr;

    initial begin
        // Table: 16 fills, three refused writes while full, idle, then a read step of one.
        for (int k = 1; k <= 16; k++)
            add_vec(1'b1, 5'd0, 1'b1, int'(g(k)), k, k == 16, k >= 15, 1'b0);
        for (int k = 0; k < 3; k++)
            add_vec(1'b1, 5'd0, 1'b0, 24, 16, 1'b1, 1'b1, 1'b1);
        add_vec(1'b0, 5'd0, 1'b0, 24, 16, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 5'd1, 1'b0, 24, 16, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 5'd1, 1'b0, 24, 16, 1'b1, 1'b1, 1'b0);
        add_vec(1'b0, 5'd1, 1'b0, 24, 15, 1'b0, 1'b1, 1'b0);

        cke = 1'b1; arst = 1'b1; rst = 1'b0;
        bus.wr_en_i = 1'b0; bus.rd_gptr_i = '0;
        #12 arst = 1'b0;
        @(posedge clk); #1;
        chk_all_zero("reset");

        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("idle_addr", int'(bus.wr_addr_o), 0);
            chk("idle_level", int'(bus.level_o), 0);
        end

        cke = 1'b0; bus.wr_en_i = 1'b1; #1;
        chk("cke0_we", int'(bus.wr_we_o), 0);
        @(posedge clk); #1;
        chk("cke0_level", int'(bus.level_o), 0);
        chk("cke0_gptr", int'(bus.wr_gptr_o), 0);
        cke = 1'b1; bus.wr_en_i = 1'b0;

        prev_gptr = bus.wr_gptr_o;
        foreach (vecs[i]) begin
            bus.wr_en_i = vecs[i].wr_en;
            bus.rd_gptr_i = vecs[i].rd_g;
            #1;
            chk($sformatf("v%0d_we", i), int'(bus.wr_we_o), int'(vecs[i].exp_we));
            @(posedge clk); #1;
            chk($sformatf("v%0d_gptr", i), int'(bus.wr_gptr_o), int'(vecs[i].exp_gptr));
            chk($sformatf("v%0d_level", i), int'(bus.level_o), int'(vecs[i].exp_level));
            chk($sformatf("v%0d_full", i), int'(bus.full_o), int'(vecs[i].exp_full));
            chk($sformatf("v%0d_afull", i), int'(bus.afull_o), int'(vecs[i].exp_afull));
            chk($sformatf("v%0d_ovf", i), int'(bus.overflow_o), int'(vecs[i].exp_ovf));
            chk($sformatf("v%0d_gray1", i), int'($countones(bus.wr_gptr_o ^ prev_gptr) <= 1), 1);
            prev_gptr = bus.wr_gptr_o;
        end

        // Wrap run against a cycle model: writer 2 of 3 cycles, reader every other cycle.
        wb = 16; rb = 1; s1 = 1; s2 = 1; full_m = 1'b0; writes = 0; cyc = 0; wrapped = 1'b0;
        while (writes < 40 && cyc < 300) begin
            wen = (cyc % 3) != 2;
            if ((cyc % 2) == 0 && rb != wb) rb = (rb + 1) & 31;
            bus.wr_en_i = wen;
            bus.rd_gptr_i = g(rb);
            #1;
            chk("wrap_we", int'(bus.wr_we_o), int'(wen & ~full_m));
            @(posedge clk); #1;
            ovf_m = wen & full_m;
            if (wen && !full_m) begin
                writes++;
                if (wb == 31) wrapped = 1'b1;
                wb = (wb + 1) & 31;
            end
            lvl_m = (wb - g2b(5'(s2))) & 31;
            full_m = (lvl_m == 16);
            s2 = s1;
            s1 = int'(g(rb));
            chk("wrap_level", int'(bus.level_o), lvl_m);
            chk("wrap_full", int'(bus.full_o), int'(full_m));
            chk("wrap_afull", int'(bus.afull_o), int'(lvl_m >= 15));
            chk("wrap_ovf", int'(bus.overflow_o), int'(ovf_m));
            chk("wrap_gptr", int'(bus.wr_gptr_o), int'(g(wb)));
            chk("wrap_addr", int'(bus.wr_addr_o), wb & 15);
            cyc++;
        end
        chk("wrap_writes", writes, 40);
        chk("wrap_seen", int'(wrapped), 1);

        // Async clear mid-burst at level 9.
        bus.wr_en_i = 1'b0; bus.rd_gptr_i = '0;
        arst = 1'b1; #1 arst = 1'b0;
        @(posedge clk); #1;
        write_n(9);
        chk("pre_arst_level", int'(bus.level_o), 9);
        #2 arst = 1'b1; #1;
        chk_all_zero("arst");
        arst = 1'b0;
        bus.wr_en_i = 1'b0;
        @(posedge clk); #1;

        // Sync clear wins over a concurrent write.
        write_n(9);
        chk("pre_rst_level", int'(bus.level_o), 9);
        rst = 1'b1;
        @(posedge clk); #1;
        chk_all_zero("rst");
        rst = 1'b0; bus.wr_en_i = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
